// File: rtl/dm_resp_if.sv
// Request/response bundle between the pre-DM store driver and the data-memory responder.
interface dm_resp_if;
  logic        req_valid;
  logic [31:0] PC;
  logic [29:0] Addr;
  logic [1:0]  offset;
  logic [3:0]  WE;
  logic [31:0] WData;
  logic [2:0]  load_type;

  logic        rdata_valid;
  logic [31:0] rdata;
  logic        err_range;
  logic        err_align;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  modport master (
    output req_valid, PC, Addr, offset, WE, WData, load_type,
    input  rdata_valid, rdata, err_range, err_align,
    input  trace_valid, trace_pc, trace_addr, trace_data
  );

  modport slave (
    input  req_valid, PC, Addr, offset, WE, WData, load_type,
    output rdata_valid, rdata, err_range, err_align,
    output trace_valid, trace_pc, trace_addr, trace_data
  );
endinterface

// File: rtl/dm_resp.sv
// Data-memory responder: byte-lane stores with write trace, 1-cycle loads with
// sign/zero extension, and alignment/range error pulses.
module dm_resp #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic       clk,
  input logic       reset,
  dm_resp_if.slave  bus
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LW   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LHU  = 3'd3;
  localparam logic [2:0] LT_LB   = 3'd4;
  localparam logic [2:0] LT_LBU  = 3'd5;

  function automatic logic we_legal(input logic [3:0] we);
    logic ok;
    case (we)
      4'b0000, 4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  lt,
                                              input logic [1:0]  off);
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [31:0] res;
    half   = off[1] ? word[31:16] : word[15:0];
    byte_v = off[0] ? half[15:8] : half[7:0];
    case (lt)
      LT_LW:   res = word;
      LT_LH:   res = {{16{half[15]}}, half};
      LT_LHU:  res = {16'h0000, half};
      LT_LB:   res = {{24{byte_v[7]}}, byte_v};
      LT_LBU:  res = {24'h00_0000, byte_v};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Per-word "written since reset" flags let reset clear the whole array in one cycle.
  logic [DEPTH-1:0]  word_vld_r;
  logic [31:0]       mem_r [DEPTH];

  logic [29:0]       diff_s;
  logic              in_range_s;
  logic [ADDR_W-1:0] idx_s;
  logic              is_load_s;
  logic              lt_bad_s;
  logic              is_store_s;
  logic              we_bad_s;
  logic              misalign_s;
  logic              load_ok_s;
  logic              range_err_s;
  logic              do_write_s;
  logic [31:0]       cur_word_s;
  logic [31:0]       merged_s;

  logic              rdata_valid_r;
  logic [31:0]       rdata_r;
  logic              err_range_r;
  logic              err_align_r;
  logic              trace_valid_r;
  logic [31:0]       trace_pc_r;
  logic [31:0]       trace_addr_r;
  logic [31:0]       trace_data_r;

  // Unsigned offset from the base; a wrapped (below-base) address lands far out of range.
  assign diff_s     = bus.Addr - BASE_WORD;
  assign in_range_s = ((diff_s >> ADDR_W) == 30'd0);
  assign idx_s      = diff_s[ADDR_W-1:0];

  // Load-type decode: legality and alignment per access width.
  always_comb begin
    is_load_s = 1'b0;
    lt_bad_s  = 1'b0;
    case (bus.load_type)
      LT_NONE: begin
        is_load_s = 1'b0;
        lt_bad_s  = 1'b0;
      end
      LT_LW: begin
        is_load_s = 1'b1;
        lt_bad_s  = (bus.offset != 2'b00);
      end
      LT_LH, LT_LHU: begin
        is_load_s = 1'b1;
        lt_bad_s  = bus.offset[0];
      end
      LT_LB, LT_LBU: begin
        is_load_s = 1'b1;
        lt_bad_s  = 1'b0;
      end
      default: begin
        is_load_s = 1'b0;
        lt_bad_s  = 1'b1;
      end
    endcase
  end

  assign is_store_s  = (bus.WE != 4'b0000);
  assign we_bad_s    = is_store_s & ~we_legal(bus.WE);
  assign misalign_s  = bus.req_valid & (lt_bad_s | we_bad_s);
  assign range_err_s = bus.req_valid & ~misalign_s & ~in_range_s;
  assign load_ok_s   = bus.req_valid & is_load_s & ~misalign_s;
  assign do_write_s  = bus.req_valid & is_store_s & ~misalign_s & in_range_s;

  // Read happens before this cycle's write lands, giving read-before-write on combined requests.
  assign cur_word_s = word_vld_r[idx_s] ? mem_r[idx_s] : 32'h0000_0000;
  assign merged_s   = lane_merge(cur_word_s, bus.WData, bus.WE);

  // Word-valid flags: cleared by reset, set by any accepted store.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_vld_r <= '0;
    end else if (do_write_s) begin
      word_vld_r[idx_s] <= 1'b1;
    end
  end

  // Storage array: whole merged word is written so stale pre-reset bytes never leak.
  always_ff @(posedge clk) begin
    if (!reset && do_write_s) begin
      mem_r[idx_s] <= merged_s;
    end
  end

  // Registered response, error and trace outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_valid_r <= 1'b0;
      rdata_r       <= 32'h0000_0000;
      err_range_r   <= 1'b0;
      err_align_r   <= 1'b0;
      trace_valid_r <= 1'b0;
      trace_pc_r    <= 32'h0000_0000;
      trace_addr_r  <= 32'h0000_0000;
      trace_data_r  <= 32'h0000_0000;
    end else begin
      rdata_valid_r <= load_ok_s;
      rdata_r       <= (load_ok_s && in_range_s) ?
                       load_extend(cur_word_s, bus.load_type, bus.offset) : 32'h0000_0000;
      err_range_r   <= range_err_s;
      err_align_r   <= misalign_s;
      trace_valid_r <= do_write_s;
      trace_pc_r    <= do_write_s ? bus.PC : 32'h0000_0000;
      trace_addr_r  <= do_write_s ? {bus.Addr, 2'b00} : 32'h0000_0000;
      trace_data_r  <= do_write_s ? merged_s : 32'h0000_0000;
    end
  end

  assign bus.rdata_valid = rdata_valid_r;
  assign bus.rdata       = rdata_r;
  assign bus.err_range   = err_range_r;
  assign bus.err_align   = err_align_r;
  assign bus.trace_valid = trace_valid_r;
  assign bus.trace_pc    = trace_pc_r;
  assign bus.trace_addr  = trace_addr_r;
  assign bus.trace_data  = trace_data_r;

endmodule

// File: tb/tb_dm_resp.sv
// Bench for dm_resp: directed scenarios plus a random run against a word-map reference model.
module tb_dm_resp;
  localparam int          ADDR_W = 12;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam longint      DEPTH  = 64'd1 << ADDR_W;

  typedef struct packed {
    logic        rv;
    logic [31:0] rd;
    logic        er;
    logic        ea;
    logic        tv;
    logic [31:0] tpc;
    logic [31:0] ta;
    logic [31:0] td;
  } resp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] mem_m [int];

  dm_resp_if bus ();

  dm_resp #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic resp_t observe();
    resp_t r;
    r.rv  = bus.rdata_valid;
    r.rd  = bus.rdata;
    r.er  = bus.err_range;
    r.ea  = bus.err_align;
    r.tv  = bus.trace_valid;
    r.tpc = bus.trace_pc;
    r.ta  = bus.trace_addr;
    r.td  = bus.trace_data;
    return r;
  endfunction

  // Reference model: applies one request to the word map and returns the next-cycle response.
  task automatic model_step(input logic rst, input logic v, input logic [31:0] pc,
                            input logic [31:0] ba, input logic [3:0] we,
                            input logic [31:0] wd, input logic [2:0] lt,
                            output resp_t e);
    longint      bal;
    int          idx;
    logic        bad;
    logic        in_rng;
    logic [31:0] old;
    logic [31:0] nw;
    logic [31:0] h;
    logic [31:0] b;
    e = '0;
    if (rst) begin
      mem_m.delete();
      return;
    end
    if (!v) return;
    bal    = longint'(ba);
    in_rng = (bal >= longint'(BASE)) && (bal < longint'(BASE) + 4 * DEPTH);
    bad    = (we != 4'd0 && !(we inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8})) ||
             (lt >= 3'd6) || (lt == 3'd1 && ba[1:0] != 2'd0) ||
             ((lt == 3'd2 || lt == 3'd3) && ba[0]);
    if (bad) begin
      e.ea = 1'b1;
      return;
    end
    if (!in_rng) begin
      e.er = 1'b1;
      e.rv = (lt >= 3'd1 && lt <= 3'd5);
      return;
    end
    idx = int'((bal - longint'(BASE)) / 4);
    old = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    if (lt >= 3'd1 && lt <= 3'd5) begin
      e.rv = 1'b1;
      h = (old >> (16 * int'(ba[1]))) & 32'hFFFF;
      b = (old >> (8 * int'(ba[1:0]))) & 32'hFF;
      case (lt)
        3'd1:    e.rd = old;
        3'd2:    e.rd = (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
        3'd3:    e.rd = h;
        3'd4:    e.rd = (b >= 32'h80) ? b + 32'hFFFF_FF00 : b;
        default: e.rd = b;
      endcase
    end
    if (we != 4'd0) begin
      nw = old;
      for (int i = 0; i < 4; i++) if (we[i]) nw[8*i +: 8] = wd[8*i +: 8];
      mem_m[idx] = nw;
      e.tv  = 1'b1;
      e.tpc = pc;
      e.ta  = {ba[31:2], 2'b00};
      e.td  = nw;
    end
  endtask

  // Drives one cycle of request (and reset), advances past the edge, returns the model's expectation.
  task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                      input logic [31:0] ba, input logic [3:0] we,
                      input logic [31:0] wd, input logic [2:0] lt, output resp_t e);
    reset         = rst;
    bus.req_valid = v;
    bus.PC        = pc;
    bus.Addr      = ba[31:2];
    bus.offset    = ba[1:0];
    bus.WE        = we;
    bus.WData     = wd;
    bus.load_type = lt;
    model_step(rst, v, pc, ba, we, wd, lt, e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resp_t e, a;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h40, 32'h10, 4'hF, 32'hDEAD_BEEF, 3'd1, e);
      a = observe();
      checks++;
      if (a !== '0) begin
        failures++;
        $display("FAIL reset_outputs got=%h want=0", a);
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 3'd0, e);
    a = observe();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h44, 32'h10, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rv !== 1'b1 || a.rd !== 32'h0) begin
      failures++;
      $display("FAIL lw_after_reset got=%h want=%h", a, e);
    end
  endtask

  task automatic test_store_load();
    resp_t e, a;
    logic [1:0]  offs [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
    logic [2:0]  lts  [4] = '{3'd4, 3'd5, 3'd2, 3'd3};
    logic [31:0] want [4] = '{32'hFFFF_FFBB, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB};
    step(1'b0, 1'b1, 32'h100, 32'h20, 4'hF, 32'h8899_AABB, 3'd0, e);
    a = observe();
    checks++;
    if (a !== e || a.td !== 32'h8899_AABB || a.ta !== 32'h20 || a.tpc !== 32'h100) begin
      failures++;
      $display("FAIL store_word_trace got=%h want=%h", a, e);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h104, 32'h20 | {30'd0, offs[i]}, 4'h0, 32'h0, lts[i], e);
      a = observe();
      checks++;
      if (a !== e || a.rd !== want[i]) begin
        failures++;
        $display("FAIL load_ext_%0d got=%h want=%h rd_want=%h", i, a, e, want[i]);
      end
    end
    step(1'b0, 1'b1, 32'h108, 32'h20, 4'b0100, 32'h0055_0000, 3'd0, e);
    a = observe();
    checks++;
    if (a !== e || a.td !== 32'h8855_AABB) begin
      failures++;
      $display("FAIL store_byte_merge got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h10C, 32'h20, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h8855_AABB) begin
      failures++;
      $display("FAIL lw_after_merge got=%h want=%h", a, e);
    end
  endtask

  task automatic test_align();
    resp_t e, a;
    logic [31:0] addrs [6] = '{32'h22, 32'h20, 32'h20, 32'h24, 32'h21, 32'h23};
    logic [3:0]  wes   [6] = '{4'h0, 4'b0110, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [2:0]  lts   [6] = '{3'd1, 3'd0, 3'd6, 3'd7, 3'd2, 3'd3};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h200, addrs[i], wes[i], 32'hFFFF_FFFF, lts[i], e);
      a = observe();
      checks++;
      if (a !== e || a.ea !== 1'b1 || a.rv !== 1'b0 || a.tv !== 1'b0) begin
        failures++;
        $display("FAIL align_%0d got=%h want=%h", i, a, e);
      end
    end
    step(1'b0, 1'b1, 32'h204, 32'h20, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h8855_AABB) begin
      failures++;
      $display("FAIL align_mem_unchanged got=%h want=%h", a, e);
    end
  endtask

  task automatic test_range();
    resp_t e, a;
    logic [31:0] addrs [6] = '{32'h4000, 32'h4000, 32'h4003, 32'h4002, 32'h4000, 32'hFFFF_FFFC};
    logic [3:0]  wes   [6] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'b0110, 4'hF};
    logic [2:0]  lts   [6] = '{3'd0, 3'd1, 3'd5, 3'd1, 3'd0, 3'd1};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 32'h300, addrs[i], wes[i], 32'h1234_5678, lts[i], e);
      a = observe();
      checks++;
      if (a !== e || a.tv !== 1'b0 || a.rd !== 32'h0) begin
        failures++;
        $display("FAIL range_%0d got=%h want=%h", i, a, e);
      end
    end
    // Last in-range word must be reachable and must not alias word 0.
    step(1'b0, 1'b1, 32'h304, 32'h3FFC, 4'hF, 32'hCAFE_F00D, 3'd0, e);
    a = observe();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL range_top_store got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h308, 32'h0, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h0) begin
      failures++;
      $display("FAIL range_no_alias got=%h want=%h", a, e);
    end
  endtask

  task automatic test_back_to_back();
    resp_t e, a;
    logic [3:0]  we_pool [10] = '{4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h6, 4'h5};
    logic [31:0] ba;
    logic [3:0]  we;
    logic [2:0]  lt;
    logic        v;
    int          sel;
    step(1'b0, 1'b1, 32'h400, 32'h24, 4'hF, 32'h8001_7F80, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h0 || a.td !== 32'h8001_7F80) begin
      failures++;
      $display("FAIL rbw_combined got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h404, 32'h24, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h8001_7F80) begin
      failures++;
      $display("FAIL store_then_load got=%h want=%h", a, e);
    end
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       ba = BASE + {$urandom_range(0, 15), 2'b00} + 32'($urandom_range(0, 3));
      else if (sel == 7) ba = BASE + 32'h3FF0 + 32'($urandom_range(0, 15));
      else if (sel == 8) ba = BASE + 32'h4000 + 32'($urandom_range(0, 31));
      else               ba = $urandom;
      we = we_pool[$urandom_range(0, 9)];
      lt = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      v  = ($urandom_range(0, 9) < 8);
      step(1'b0, v, $urandom, ba, we, $urandom, lt, e);
      a = observe();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL random_%0d ba=%h we=%h lt=%0d v=%0d got=%h want=%h", n, ba, we, lt, v, a, e);
      end
    end
  endtask

  task automatic test_reset_squash();
    resp_t e, a;
    step(1'b0, 1'b1, 32'h500, 32'h20, 4'hF, 32'hA5A5_5A5A, 3'd0, e);
    step(1'b0, 1'b1, 32'h504, 32'h20, 4'h0, 32'h0, 3'd1, e);
    step(1'b1, 1'b1, 32'h508, 32'h20, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a.rv !== 1'b0 || a !== '0) begin
      failures++;
      $display("FAIL reset_squash got=%h want=0", a);
    end
    step(1'b0, 1'b1, 32'h50C, 32'h20, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rv !== 1'b1 || a.rd !== 32'h0) begin
      failures++;
      $display("FAIL mem_cleared_20 got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h510, 32'h3FFC, 4'h0, 32'h0, 3'd1, e);
    a = observe();
    checks++;
    if (a !== e || a.rd !== 32'h0) begin
      failures++;
      $display("FAIL mem_cleared_top got=%h want=%h", a, e);
    end
    step(1'b0, 1'b1, 32'h514, 32'h20, 4'b0001, 32'h0000_00FF, 3'd0, e);
    a = observe();
    checks++;
    if (a !== e || a.td !== 32'h0000_00FF) begin
      failures++;
      $display("FAIL merge_after_reset got=%h want=%h", a, e);
    end
  endtask

  initial begin
    resp_t e;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req_valid = 1'b0;
    bus.PC        = 32'h0;
    bus.Addr      = 30'h0;
    bus.offset    = 2'b00;
    bus.WE        = 4'h0;
    bus.WData     = 32'h0;
    bus.load_type = 3'd0;
    test_reset();
    test_store_load();
    test_align();
    test_range();
    test_back_to_back();
    test_reset_squash();
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 3'd0, e);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
